// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs from ID/EX/MEM and
// the per-stage enable, bubble and flush controls returned to the datapath.
interface pipeline_hazard_ctrl_if;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic [4:0] ID_EX_rt;
    logic       ID_EX_mem_read;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_write;
    logic       IF_ID_write;
    logic       IF_ID_flush;
    logic       ID_EX_write;
    logic       ID_EX_bubble;
    logic       EX_MEM_write;
    logic       MEM_WB_bubble;

    modport master (
        output IF_ID_rs, IF_ID_rt, ID_EX_rt, ID_EX_mem_read, branch_taken,
               dmem_req, dmem_ready,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
               EX_MEM_write, MEM_WB_bubble
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, ID_EX_rt, ID_EX_mem_read, branch_taken,
               dmem_req, dmem_ready,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
               EX_MEM_write, MEM_WB_bubble
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// with watchdog. Define HAZARD_PERF_EN to implement the stall_count performance counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [1:0]            ctrl_state,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                err_nxt;
    logic                load_use, mem_miss;
    logic                pc_write_c, if_id_write_c, if_id_flush_c, id_ex_write_c;
    logic                id_ex_bubble_c, ex_mem_write_c, mem_wb_bubble_c;

    assign load_use = hz.ID_EX_mem_read && (hz.ID_EX_rt != 5'd0) &&
                      ((hz.ID_EX_rt == hz.IF_ID_rs) || (hz.ID_EX_rt == hz.IF_ID_rt));
    assign mem_miss = hz.dmem_req && !hz.dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            mem_timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        err_nxt         = mem_timeout_err;
        pc_write_c      = 1'b1;
        if_id_write_c   = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_write_c   = 1'b1;
        id_ex_bubble_c  = 1'b0;
        ex_mem_write_c  = 1'b1;
        mem_wb_bubble_c = 1'b0;

        // A freeze holds every stage up to MEM and drains a NOP into WB.
        if ((state == ST_ERR) || (state == ST_MEM_WAIT && !hz.dmem_ready) ||
            (state == ST_RUN && mem_miss)) begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            id_ex_write_c   = 1'b0;
            ex_mem_write_c  = 1'b0;
            mem_wb_bubble_c = 1'b1;
        end else if (hz.branch_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (load_use) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
        end

        case (state)
            ST_RUN: begin
                if (mem_miss) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_nxt = ST_ERR;
                    err_nxt   = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Controls are forced inactive while reset is asserted.
    assign hz.pc_write      = rst_n & pc_write_c;
    assign hz.IF_ID_write   = rst_n & if_id_write_c;
    assign hz.IF_ID_flush   = rst_n & if_id_flush_c;
    assign hz.ID_EX_write   = rst_n & id_ex_write_c;
    assign hz.ID_EX_bubble  = rst_n & id_ex_bubble_c;
    assign hz.EX_MEM_write  = rst_n & ex_mem_write_c;
    assign hz.MEM_WB_bubble = rst_n & mem_wb_bubble_c;
    assign ctrl_state       = state;

`ifdef HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (!pc_write_c)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for single-cycle decisions
// plus hand-written memory-wait, watchdog and asynchronous-reset sequences.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    // Output bundle order: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
    //                       ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
    localparam logic [6:0] O_RUN   = 7'b1101010;
    localparam logic [6:0] O_STALL = 7'b0001110;
    localparam logic [6:0] O_FLUSH = 7'b1111110;
    localparam logic [6:0] O_FRZ   = 7'b0000001;
    localparam logic [6:0] O_ZERO  = 7'b0000000;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ex_rt;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [1:0] st;
        logic [6:0] o;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [1:0]       ctrl_state;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_count;

    int checks;
    int errors;
    int exp_stall;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hz              (hz.slave),
        .ctrl_state      (ctrl_state),
        .mem_timeout_err (mem_timeout_err),
        .stall_count     (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] outs();
        return {hz.pc_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_write,
                hz.ID_EX_bubble, hz.EX_MEM_write, hz.MEM_WB_bubble};
    endfunction

    function automatic int exp_cnt();
`ifdef HAZARD_PERF_EN
        return exp_stall;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                         input logic mr, input logic br, input logic req, input logic rdy);
        hz.IF_ID_rs       = rs;
        hz.IF_ID_rt       = rt;
        hz.ID_EX_rt       = ex_rt;
        hz.ID_EX_mem_read = mr;
        hz.branch_taken   = br;
        hz.dmem_req       = req;
        hz.dmem_ready     = rdy;
    endtask

    // Advance one clock, crediting a stall when pc_write was expected low.
    task automatic tick(input logic [6:0] exp_o);
        if (!exp_o[6]) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_stall = 0;
        #1;
    endtask

    vec_t tbl [19];

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        rst_n     = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        tbl[0]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_RUN};
        tbl[1]  = '{5'd8,  5'd3, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, O_STALL};
        tbl[2]  = '{5'd4,  5'd8, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, O_STALL};
        tbl[3]  = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, O_RUN};
        tbl[4]  = '{5'd8,  5'd8, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_RUN};
        tbl[5]  = '{5'd8,  5'd0, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 2'b00, O_FLUSH};
        tbl[6]  = '{5'd1,  5'd2, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, O_FLUSH};
        tbl[7]  = '{5'd9,  5'd1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 2'b00, O_STALL};
        tbl[8]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'b00, O_FRZ};
        tbl[9]  = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2'b01, O_FRZ};
        tbl[10] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 2'b01, O_FLUSH};
        tbl[11] = '{5'd5,  5'd6, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 2'b00, O_FRZ};
        tbl[12] = '{5'd7,  5'd6, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 2'b01, O_STALL};
        tbl[13] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, O_RUN};
        tbl[14] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, O_FRZ};
        tbl[15] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, O_FRZ};
        tbl[16] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b01, O_RUN};
        tbl[17] = '{5'd31, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, O_STALL};
        tbl[18] = '{5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, O_RUN};

        // Reset state
        #12;
        chk("reset_outs", 32'(outs()), 32'(O_ZERO));
        chk("reset_state", 32'(ctrl_state), 32'd0);
        chk("reset_err", 32'(mem_timeout_err), 32'd0);
        chk("reset_cnt", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        // Vector table
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].ex_rt, tbl[i].mr, tbl[i].br,
                  tbl[i].req, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d_state", i), 32'(ctrl_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].o));
            tick(tbl[i].o);
        end
        chk("table_state_end", 32'(ctrl_state), 32'd0);
        chk("table_stall_cnt", 32'(stall_count), 32'(exp_cnt()));

        // Memory wait: three ready-low cycles then ready
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw%0d_state", i), 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("mw%0d_outs", i), 32'(outs()), 32'(O_FRZ));
            tick(O_FRZ);
        end
        hz.dmem_ready = 1'b1;
        #1;
        chk("mw_ready_state", 32'(ctrl_state), 32'd1);
        chk("mw_ready_outs", 32'(outs()), 32'(O_RUN));
        tick(O_RUN);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mw_after_state", 32'(ctrl_state), 32'd0);
        chk("mw_stall_cnt", 32'(stall_count), 32'(exp_cnt()));

        // Watchdog: ready held low
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #1;
            chk($sformatf("wd%0d_state", i), 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("wd%0d_err", i), 32'(mem_timeout_err), 32'd0);
            tick(O_FRZ);
        end
        #1;
        chk("wd_err_state", 32'(ctrl_state), 32'd2);
        chk("wd_err_flag", 32'(mem_timeout_err), 32'd1);
        chk("wd_err_outs", 32'(outs()), 32'(O_FRZ));
        tick(O_FRZ);
        drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wd_hold%0d_state", i), 32'(ctrl_state), 32'd2);
            chk($sformatf("wd_hold%0d_outs", i), 32'(outs()), 32'(O_FRZ));
            tick(O_FRZ);
        end
        chk("wd_hold_flag", 32'(mem_timeout_err), 32'd1);
        chk("wd_stall_cnt", 32'(stall_count), 32'(exp_cnt()));

        // Asynchronous reset in the middle of a memory wait
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(O_FRZ);
        tick(O_FRZ);
        chk("ar_pre_state", 32'(ctrl_state), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        chk("ar_state", 32'(ctrl_state), 32'd0);
        chk("ar_cnt", 32'(stall_count), 32'd0);
        chk("ar_err", 32'(mem_timeout_err), 32'd0);
        chk("ar_outs", 32'(outs()), 32'(O_ZERO));
        @(posedge clk);
        #1;
        chk("ar_held_outs", 32'(outs()), 32'(O_ZERO));
        chk("ar_held_state", 32'(ctrl_state), 32'd0);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("ar_release_outs", 32'(outs()), 32'(O_RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequences the 5-stage MIPS pipeline: generates per-stage write-enable, bubble and flush controls for load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses (req/ready handshake) in MEM. Sits beside the forwarding unit; forwarding covers ALU-to-ALU dependencies, and this block stalls whatever forwarding cannot cover. Includes a memory-wait watchdog and a stall performance counter.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before the watchdog fires (>=2)
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
IF_ID_rs  in  5  rs of instruction in ID
IF_ID_rt  in  5  rt of instruction in ID
ID_EX_rt  in  5  destination rt of instruction in EX
ID_EX_mem_read  in  1  instruction in EX is a load
branch_taken  in  1  branch/jump in EX resolved taken
dmem_req  in  1  MEM stage performs a valid memory access this cycle
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  IF/ID register cleared to NOP
ID_EX_write  out  1  ID/EX register enable
ID_EX_bubble  out  1  ID/EX loads NOP (control zeroed)
EX_MEM_write  out  1  EX/MEM register enable
MEM_WB_bubble  out  1  MEM/WB loads NOP
ctrl_state  out  2  00 RUN, 01 MEM_WAIT, 10 ERR
mem_timeout_err  out  1  sticky watchdog flag
stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (rst_n=0, async): state RUN, wait counter 0, stall_count 0, mem_timeout_err 0. While rst_n=0 all write enables =0 and all flush/bubble =0.
- Control outputs are combinational from the registered state and current inputs; state, counters and the error flag are registered.
- Default in RUN: all write enables =1, all flush/bubble =0.
- Load-use detection: load_use = ID_EX_mem_read && ID_EX_rt!=0 && (ID_EX_rt==IF_ID_rs || ID_EX_rt==IF_ID_rt).
- Priority in RUN (highest first):
  1. mem_miss = dmem_req && !dmem_ready: pc_write, IF_ID_write, ID_EX_write and EX_MEM_write =0; MEM_WB_bubble=1. Next state MEM_WAIT, wait counter <=1.
  2. branch_taken: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1. Any concurrent load_use is ignored because the dependent instruction is flushed.
  3. load_use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1. Exactly one bubble, since the load advances to MEM on the next cycle.
- MEM_WAIT:
  - dmem_ready=0: same freeze as mem_miss; wait counter increments.
  - dmem_ready=1: the pipeline advances this cycle and rules 2/3 apply to current inputs; next state RUN, counter <=0.
  - ready=0 with counter==MEM_TIMEOUT-1: next state ERR, mem_timeout_err<=1.
- Branch held in EX during a freeze re-presents on exit and is honoured then. Frozen stages do not lose instructions.
- ERR: all write enables =0, MEM_WB_bubble=1, flush/bubble others 0. Only reset leaves ERR. dmem_ready is ignored.
- stall_count increments every cycle pc_write=0 (including ERR) and saturates at all-ones.
- dmem_req is sampled only in RUN; in MEM_WAIT the request is implicitly held.

Optional Feature:
HAZARD_PERF_EN
- Defined: stall_count is implemented as above.
- Undefined: no counter register; stall_count is tied to 0. All other behaviour is identical.

Test Plan:
- Load-use: ID_EX_mem_read=1, ID_EX_rt=8, IF_ID_rs=8 for one cycle -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 that cycle only. With ID_EX_rt=0 -> no stall.
- Branch: branch_taken=1 with load_use also true -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1. stall_count unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> ctrl_state=01 for 3 cycles, freeze outputs, MEM_WB_bubble=1; RUN on the cycle after ready; stall_count=3.
- Watchdog: dmem_req=1, ready held 0 -> after MEM_TIMEOUT=16 cycles ctrl_state=10, mem_timeout_err=1. It stays set with ready=1 until rst_n pulse.
- Branch and miss together: branch_taken=1 and mem_miss in same cycle -> freeze wins, no flush. On the ready cycle with branch_taken still 1 -> IF_ID_flush=1.
- Async reset mid MEM_WAIT: rst_n low between clock edges -> ctrl_state=00 and counters 0 immediately; write enables 0 until release.
